// File: rtl/spi_cfg_pkg.sv
// spi_cfg_pkg: shared types and constants for the SPI configuration register bank
//   state_t      : frame FSM states
//   CMD_BITS     : length of the command byte
//   WR_BIT       : position of the write flag inside the command byte
//   DEF_RST_VALS : default reset value per register, index 0 = register 0
package spi_cfg_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA, ST_DONE} state_t;
   localparam int CMD_BITS = 8;
   localparam int WR_BIT = 7;
   localparam logic [31:0] DEF_RST_VALS [8] = '{
      32'h0000_A8C0, 32'h0000_AF00, 32'h1, 32'h1, 32'h0, 32'h0010, 32'h0, 32'h0
   };
endpackage

// File: rtl/spi_cfg_regbank_sync.sv
// spi_sync: two-flop synchronizer for one asynchronous SPI input
//   clk, rst_n : system clock, asynchronous active-low reset
//   d          : asynchronous input
//   q          : synchronized output, RST_VAL while in reset
module spi_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic meta;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/spi_cfg_regbank.sv
// spi_cfg_regbank: SPI mode-0 slave giving read/write access to a bank of configuration registers
//   clk, rst_n      : system clock, asynchronous active-low reset
//   spi_sclk/cs_n   : SPI clock and chip select, asynchronous to clk
//   spi_mosi        : serial data in, command byte then DATA_W data bits, MSB first
//   spi_miso        : serial read data, straight from a clk-domain flop
//   cfg_q           : register i at [i*DATA_W +: DATA_W]
//   cfg_wr          : one-cycle strobe of the register that was written
//   config_updated  : one-cycle pulse on any committed write
//   frame_err       : one-cycle pulse on an aborted frame or an out-of-range address
module spi_cfg_regbank
   import spi_cfg_pkg::*;
#(
   parameter int NUM_REGS = 8,
   parameter int DATA_W = 32,
   parameter logic [31:0] RST_VALS [NUM_REGS] = DEF_RST_VALS
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       spi_sclk,
   input  logic                       spi_cs_n,
   input  logic                       spi_mosi,
   output logic                       spi_miso,
   output logic [NUM_REGS*DATA_W-1:0] cfg_q,
   output logic [NUM_REGS-1:0]        cfg_wr,
   output logic                       config_updated,
   output logic                       frame_err
);
   localparam int CW = $clog2(DATA_W + CMD_BITS);
   localparam logic [CW-1:0] CMD_LAST = CW'(CMD_BITS - 1);
   localparam logic [CW-1:0] CMD_DONE = CW'(CMD_BITS);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W + CMD_BITS - 1);

   logic sclk_s, cs_s, mosi_s, sclk_d, cs_d, rise, fall, cs_fall, addr_ok, cmd_ok, wr;
   logic [2:0] rdy;
   logic [CW-1:0] cnt;
   logic [6:0] addr;
   logic [DATA_W-2:0] sh_in;
   logic [DATA_W-1:0] sh_next, sh_out, rd_val;
   logic [CMD_BITS-1:0] cmd;
   logic [DATA_W-1:0] regs [NUM_REGS];
   state_t state;

   spi_sync #(.RST_VAL(1'b0)) u_sclk (.clk(clk), .rst_n(rst_n), .d(spi_sclk), .q(sclk_s));
   spi_sync #(.RST_VAL(1'b1)) u_cs   (.clk(clk), .rst_n(rst_n), .d(spi_cs_n), .q(cs_s));
   spi_sync #(.RST_VAL(1'b0)) u_mosi (.clk(clk), .rst_n(rst_n), .d(spi_mosi), .q(mosi_s));

   assign rise = sclk_s & ~sclk_d;
   assign fall = ~sclk_s & sclk_d;
   // rdy holds off edge detection until cs_d carries a real post-reset sample,
   // so a cs_n held low through reset never looks like a fresh falling edge
   assign cs_fall = rdy[2] & cs_d & ~cs_s;
   assign sh_next = {sh_in, mosi_s};
   assign cmd = sh_next[CMD_BITS-1:0];
   assign cmd_ok = {1'b0, cmd[6:0]} < 8'(NUM_REGS);
   assign addr_ok = {1'b0, addr} < 8'(NUM_REGS);
   assign spi_miso = sh_out[DATA_W-1];

   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NUM_REGS; i++) rd_val = (cmd[6:0] == 7'(i)) ? regs[i] : rd_val;
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
      assign cfg_q[g*DATA_W +: DATA_W] = regs[g];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt <= '0;
         sh_in <= '0;
         sh_out <= '0;
         addr <= '0;
         wr <= 1'b0;
         sclk_d <= 1'b0;
         cs_d <= 1'b1;
         rdy <= '0;
         cfg_wr <= '0;
         config_updated <= 1'b0;
         frame_err <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VALS[i][DATA_W-1:0];
      end else begin
         sclk_d <= sclk_s;
         cs_d <= cs_s;
         rdy <= {rdy[1:0], 1'b1};
         cfg_wr <= '0;
         config_updated <= 1'b0;
         frame_err <= 1'b0;
         // cs_n high wins over any sclk edge seen in the same cycle
         if (cs_s) begin
            state <= ST_IDLE;
            sh_out <= '0;
            frame_err <= (state == ST_CMD) || (state == ST_DATA);
         end else begin
            case (state)
               ST_IDLE: if (cs_fall) begin
                  state <= ST_CMD;
                  cnt <= '0;
               end
               ST_CMD: if (rise) begin
                  sh_in <= sh_next[DATA_W-2:0];
                  cnt <= cnt + 1'b1;
                  if (cnt == CMD_LAST) begin
                     state <= ST_DATA;
                     wr <= cmd[WR_BIT];
                     addr <= cmd[6:0];
                     sh_out <= (!cmd[WR_BIT] && cmd_ok) ? rd_val : '0;
                     frame_err <= !cmd[WR_BIT] && !cmd_ok;
                  end
               end
               ST_DATA: if (rise) begin
                  sh_in <= sh_next[DATA_W-2:0];
                  cnt <= cnt + 1'b1;
                  if (cnt == DATA_LAST) begin
                     state <= ST_DONE;
                     sh_out <= '0;
                     config_updated <= wr && addr_ok;
                     frame_err <= wr && !addr_ok;
                     for (int i = 0; i < NUM_REGS; i++) begin
                        if (wr && addr == 7'(i)) begin
                           regs[i] <= sh_next;
                           cfg_wr[i] <= 1'b1;
                        end
                     end
                  end
               // the falling edge that closes the command byte must not shift:
               // the master has not yet sampled the first data bit
               end else if (fall && cnt != CMD_DONE) begin
                  sh_out <= {sh_out[DATA_W-2:0], 1'b0};
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_spi_cfg_regbank.sv
// tb_spi_cfg_regbank: self-checking bench, directed table plus random frames against a frame-level model
module tb_spi_cfg_regbank;
   logic clk = 0, rst_n = 0, spi_sclk = 0, spi_cs_n = 1, spi_mosi = 0;
   logic spi_miso, config_updated, frame_err;
   logic [255:0] cfg_q;
   logic [7:0] cfg_wr;
   int checks = 0, errors = 0;
   int wr_cnt [8];
   int cu_cnt = 0, err_cnt = 0, cyc_cnt = 0;
   logic [31:0] mdl [8];

   typedef struct {
      logic [7:0] cmd;
      logic [31:0] data;
      int nbits;
      bit cs_last;
      bit tbl;
      int ridx;
      logic [31:0] rval;
      int err;
      logic [7:0] wrmask;
      logic [31:0] miso;
   } vec_t;

   vec_t tbl [10];

   spi_cfg_regbank dut (
      .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso), .cfg_q(cfg_q), .cfg_wr(cfg_wr),
      .config_updated(config_updated), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      for (int i = 0; i < 8; i++) if (cfg_wr[i]) wr_cnt[i]++;
      if (cfg_wr != 0) cyc_cnt++;
      if (config_updated) cu_cnt++;
      if (frame_err) err_cnt++;
   end

   function automatic logic [31:0] reg_of(input int i);
      return cfg_q[i*32 +: 32];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic mdl_reset();
      mdl = '{32'h0000_A8C0, 32'h0000_AF00, 32'h1, 32'h1, 32'h0, 32'h10, 32'h0, 32'h0};
   endtask

   task automatic send_bit(input logic b, input logic raise_cs, output logic m);
      spi_mosi = b;
      repeat (8) @(negedge clk);
      spi_sclk = 1;
      m = spi_miso;
      if (raise_cs) spi_cs_n = 1;
      repeat (8) @(negedge clk);
      spi_sclk = 0;
   endtask

   task automatic drive_frame(input vec_t v, output logic [31:0] mw);
      logic [39:0] bits;
      logic m;
      bits = {v.cmd, v.data};
      mw = '0;
      spi_cs_n = 0;
      repeat (16) @(negedge clk);
      for (int b = 0; b < v.nbits; b++) begin
         send_bit(bits[39-b], v.cs_last && b == v.nbits - 1, m);
         if (b >= 8) mw[39-b] = m;
      end
      repeat (8) @(negedge clk);
      spi_cs_n = 1;
      repeat (16) @(negedge clk);
   endtask

   task automatic run_vec(input vec_t v);
      int e0, c0, y0;
      int w0 [8];
      logic [31:0] mw, x_miso;
      logic [7:0] mask, x_mask;
      logic [6:0] a;
      logic wr, ok, full;
      int d_err, x_err;
      e0 = err_cnt; c0 = cu_cnt; y0 = cyc_cnt; w0 = wr_cnt;
      drive_frame(v, mw);
      d_err = err_cnt - e0;
      for (int i = 0; i < 8; i++) mask[i] = wr_cnt[i] != w0[i];
      a = v.cmd[6:0];
      wr = v.cmd[7];
      ok = a < 7'd8;
      full = v.nbits == 40 && !v.cs_last;
      x_err = int'(!full) + int'(!wr && !ok && v.nbits >= 8) + int'(full && wr && !ok);
      x_mask = (full && wr && ok) ? 8'(1 << a) : 8'h0;
      if (x_mask != 0) mdl[a[2:0]] = v.data;
      x_miso = (!wr && ok) ? mdl[a[2:0]] : 32'h0;
      chk($sformatf("err_pulses cmd=%h", v.cmd), d_err, x_err);
      chk($sformatf("wr_mask cmd=%h", v.cmd), mask, x_mask);
      chk($sformatf("wr_cycles cmd=%h", v.cmd), cyc_cnt - y0, (x_mask != 0) ? 1 : 0);
      chk($sformatf("cfg_updated cmd=%h", v.cmd), cu_cnt - c0, (x_mask != 0) ? 1 : 0);
      if (v.nbits == 40) chk($sformatf("miso_word cmd=%h", v.cmd), mw, x_miso);
      for (int i = 0; i < 8; i++) chk($sformatf("reg%0d cmd=%h", i, v.cmd), reg_of(i), mdl[i]);
      chk("idle_miso", spi_miso, 0);
      if (v.tbl) begin
         chk($sformatf("tbl_reg cmd=%h", v.cmd), reg_of(v.ridx), v.rval);
         chk($sformatf("tbl_err cmd=%h", v.cmd), d_err, v.err);
         chk($sformatf("tbl_mask cmd=%h", v.cmd), mask, v.wrmask);
         if (v.nbits == 40) chk($sformatf("tbl_miso cmd=%h", v.cmd), mw, v.miso);
      end
   endtask

   initial begin
      vec_t v;
      logic m;
      int y0, e0;
      //            cmd    data           nbits cs_last tbl ridx rval           err mask   miso
      tbl[0] = '{8'h80, 32'h12345678, 40, 1'b0, 1'b1, 0, 32'h12345678, 0, 8'h01, 32'h0};
      tbl[1] = '{8'h01, 32'h0,        40, 1'b0, 1'b1, 1, 32'h0000AF00, 0, 8'h00, 32'h0000AF00};
      tbl[2] = '{8'h83, 32'hCAFEF00D, 28, 1'b0, 1'b1, 3, 32'h1,        1, 8'h00, 32'h0};
      tbl[3] = '{8'h8A, 32'hDEADBEEF, 40, 1'b0, 1'b1, 2, 32'h1,        1, 8'h00, 32'h0};
      tbl[4] = '{8'h0A, 32'h0,        40, 1'b0, 1'b1, 0, 32'h12345678, 1, 8'h00, 32'h0};
      tbl[5] = '{8'h85, 32'h000000AB, 40, 1'b1, 1'b1, 5, 32'h10,       1, 8'h00, 32'h0};
      tbl[6] = '{8'h00, 32'h0,        40, 1'b0, 1'b1, 0, 32'h12345678, 0, 8'h00, 32'h12345678};
      tbl[7] = '{8'hFF, 32'h55AA55AA, 40, 1'b0, 1'b1, 7, 32'h0,        1, 8'h00, 32'h0};
      tbl[8] = '{8'h87, 32'h0F0F0F0F, 40, 1'b0, 1'b1, 7, 32'h0F0F0F0F, 0, 8'h80, 32'h0};
      tbl[9] = '{8'h07, 32'h0,        40, 1'b0, 1'b1, 7, 32'h0F0F0F0F, 0, 8'h00, 32'h0F0F0F0F};
      mdl_reset();
      repeat (5) @(negedge clk);
      rst_n = 1;
      repeat (10) @(negedge clk);
      chk("rst_reg0", reg_of(0), 32'h0000A8C0);
      chk("rst_reg1", reg_of(1), 32'h0000AF00);
      chk("rst_reg5", reg_of(5), 32'h00000010);
      for (int i = 0; i < 8; i++) chk($sformatf("rst_reg%0d", i), reg_of(i), mdl[i]);
      chk("rst_pulses", cyc_cnt + cu_cnt + err_cnt, 0);
      chk("rst_miso", spi_miso, 0);
      for (int t = 0; t < 10; t++) run_vec(tbl[t]);
      // reset in the middle of a write to reg2, then keep clocking with cs_n still low
      spi_cs_n = 0;
      repeat (16) @(negedge clk);
      for (int b = 0; b < 12; b++) send_bit(b == 0 || b == 6, 1'b0, m);
      rst_n = 0;
      repeat (4) @(negedge clk);
      mdl_reset();
      chk("midrst_reg2", reg_of(2), 32'h1);
      chk("midrst_reg0", reg_of(0), 32'h0000A8C0);
      chk("midrst_wr", cfg_wr, 0);
      chk("midrst_err", frame_err, 0);
      y0 = cyc_cnt; e0 = err_cnt;
      rst_n = 1;
      for (int b = 0; b < 28; b++) send_bit(1'b1, 1'b0, m);
      repeat (8) @(negedge clk);
      spi_cs_n = 1;
      repeat (16) @(negedge clk);
      chk("postrst_reg2", reg_of(2), 32'h1);
      chk("postrst_wr", cyc_cnt - y0, 0);
      chk("postrst_err", err_cnt - e0, 0);
      v = '{8'h82, 32'h0BADF00D, 40, 1'b0, 1'b1, 2, 32'h0BADF00D, 0, 8'h04, 32'h0};
      run_vec(v);
      for (int r = 0; r < 20; r++) begin
         v.cmd = 8'($urandom);
         if ($urandom_range(0, 3) != 0) v.cmd[6:0] = 7'($urandom_range(0, 7));
         v.data = $urandom;
         v.nbits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 39)) : 40;
         v.cs_last = v.nbits == 40 && $urandom_range(0, 7) == 0;
         v.tbl = 1'b0;
         run_vec(v);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/spi_cfg_regbank.md
SPI_CFG_REGBANK -- requirements
Module: spi_cfg_regbank

Interface
REQ-001 Parameters SHALL be, one per line:
  NUM_REGS, default 8, number of configuration registers (1..128).
  DATA_W, default 32, register width in bits (8..32, multiple of 8).
  RST_VALS, default {32'h0000_A8C0, 32'h0000_AF00, 32'h1, 32'h1, 32'h0, 32'h0010, 32'h0, 32'h0}, reset value per register.
REQ-002 Ports SHALL be, one per line:
  clk  in  1  system clock, only clock of the block.
  rst_n  in  1  asynchronous active-low reset.
  spi_sclk  in  1  SPI clock, mode 0, asynchronous to clk.
  spi_cs_n  in  1  SPI chip select, active low, asynchronous.
  spi_mosi  in  1  SPI serial data in, MSB first.
  spi_miso  out  1  SPI serial data out, registered in clk domain.
  cfg_q  out  NUM_REGS*DATA_W  flat register contents, reg i at [i*DATA_W +: DATA_W].
  cfg_wr  out  NUM_REGS  one-cycle write strobe per register.
  config_updated  out  1  one-cycle pulse on any committed write.
  frame_err  out  1  one-cycle pulse on aborted frame or bad address.

Function
REQ-003 spi_sclk, spi_cs_n and spi_mosi SHALL each pass a 2-flop synchronizer; sclk edges SHALL be detected from synchronized samples; spi_sclk frequency SHALL be at most clk/8.
REQ-004 Frame SHALL be: command byte (bit7 = 1 write / 0 read, bits6:0 address), then DATA_W data bits, MSB first, MOSI sampled on detected rising sclk.
REQ-005 FSM states SHALL be IDLE, CMD, DATA, DONE.
REQ-006 IDLE -> CMD on synchronized cs_n falling; bit counter cleared.
REQ-007 CMD -> DATA on 8th detected rising edge; address and R/W latched that cycle.
REQ-008 DATA -> DONE on DATA_W-th rising edge after command byte.
REQ-009 Any state -> IDLE when synchronized cs_n is high; DONE ignores further sclk edges.
REQ-010 Write commit: in the cycle after DATA -> DONE, addressed register SHALL load shifted data, and cfg_wr[addr] and config_updated SHALL pulse high for one cycle.
REQ-011 Address >= NUM_REGS SHALL suppress the write and read data; frame_err SHALL pulse on the cycle a write would have committed, or on CMD -> DATA for reads.
REQ-012 cs_n high before DONE SHALL abort the frame: no register change, frame_err pulses one cycle; a cs_n rise and sclk edge detected in the same cycle SHALL be treated as abort (cs_n wins).
REQ-013 Read: on CMD -> DATA with R/W = 0, the addressed register SHALL be loaded into an output shifter; MISO SHALL present the shifter MSB from that cycle and shift on each detected falling sclk edge.
REQ-014 spi_miso SHALL be 0 in IDLE, CMD, DONE, and for out-of-range reads.
REQ-015 Register bits above DATA_W of RST_VALS entries SHALL be ignored; no arithmetic beyond bit counter ($clog2(DATA_W+8) bits, saturating in DONE).

Reset
REQ-016 rst_n low SHALL asynchronously set FSM to IDLE, counters and shifters to 0, spi_miso 0, cfg_wr 0, config_updated 0, frame_err 0, cfg_q to RST_VALS.
REQ-017 Reset mid-frame SHALL discard the frame; after release, a new cs_n falling edge is required before a frame starts.

Structure
REQ-018 Package spi_cfg_pkg SHALL hold the FSM state enum, CMD_BITS = 8, the write-bit position, and default reset-value constants.
REQ-019 One sub-module spi_sync (2-flop synchronizer, reset to 1 for cs_n and 0 otherwise, via parameter) SHALL be instantiated per SPI input.

Verification
REQ-020 Reset, no SPI activity -> cfg_q reg0 = 0x0000A8C0, reg1 = 0x0000AF00, reg5 = 0x00000010; all pulses 0.
REQ-021 Write 0x80 + data 0x12345678 -> reg0 = 0x12345678, cfg_wr = 8'b0000_0001 and config_updated high exactly one cycle.
REQ-022 Read cmd 0x01 after reset -> MISO returns 0x0000AF00 MSB first over 32 sclk periods.
REQ-023 Write cmd 0x83 with cs_n raised after 20 data bits -> reg3 stays 0x00000001, frame_err pulses once, no cfg_wr.
REQ-024 Write cmd 0x8A (addr 10, NUM_REGS = 8) + 0xDEADBEEF -> no register change, frame_err pulses; read cmd 0x0A -> MISO all 0.
REQ-025 rst_n asserted after 12 bits of a write to reg2 -> reg2 = 0x00000001; next full write frame to reg2 commits normally.
